// File: rtl/ysyx_25040109_ifu_prefetch.sv
// ============================================================================
// Module      : ysyx_25040109_ifu_prefetch
// Description : Instruction-fetch front end. Issues sequential reads ahead of
//               decode (bounded by MAX_OUTSTANDING and FIFO space), buffers
//               returned words with their PCs in an in-order FIFO, and
//               discards stale in-flight responses after a redirect.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_25040109_ifu_prefetch #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       imem_arvalid,
    input  logic                       imem_arready,
    output logic [31:0]                imem_araddr,
    input  logic                       imem_rvalid,
    output logic                       imem_rready,
    input  logic [31:0]                imem_rdata,
    input  logic [1:0]                 imem_rresp,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [31:0]                out_pc,
    output logic                       out_fault,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_OST_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_OST_W-1:0] c_MAX_OST = c_OST_W'(MAX_OUTSTANDING);

    // Fetch / response tracking state
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        resp_pc_q, resp_pc_d;
    logic [31:0]        araddr_q, araddr_d;
    logic               ar_hold_q, ar_hold_d;
    logic               ar_stale_q, ar_stale_d;
    logic               fault_stall_q, fault_stall_d;
    logic [c_OST_W-1:0] outstanding_q, outstanding_d;
    logic [c_OST_W-1:0] stale_cnt_q, stale_cnt_d;

    // FIFO state
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic [31:0]        inst_mem_q  [DEPTH];
    logic [31:0]        pc_mem_q    [DEPTH];
    logic               fault_mem_q [DEPTH];

    logic [31:0] w_committed;
    logic        w_credit;
    logic        w_ar_fire;
    logic        w_ar_is_stale;
    logic        w_r_fire;
    logic        w_drop;
    logic        w_push;
    logic        w_pop;

    // FIFO slots already promised: buffered entries plus reads in flight
    assign w_committed = 32'(count_q) + 32'(outstanding_q);

    // A fresh request may only start when nothing is being held on the bus
    assign w_credit = rst && !ar_hold_q && !fault_stall_q && !redirect_valid
                      && (outstanding_q < c_MAX_OST)
                      && (w_committed < 32'(DEPTH));

    assign imem_arvalid = (rst && ar_hold_q) || w_credit;
    assign imem_araddr  = ar_hold_q ? araddr_q : fetch_pc_q;
    assign imem_rready  = rst;

    assign w_ar_fire     = imem_arvalid && imem_arready;
    // A held request that outlived a redirect belongs to the old stream
    assign w_ar_is_stale = ar_hold_q && ar_stale_q;
    // Responses with nothing in flight (e.g. after a reset) are ignored
    assign w_r_fire      = imem_rvalid && imem_rready && (outstanding_q != '0);
    assign w_drop        = w_r_fire && (stale_cnt_q != '0);
    assign w_push        = w_r_fire && !w_drop;
    assign w_pop         = out_valid && out_ready;

    assign out_valid = (count_q != '0);
    assign out_inst  = inst_mem_q[rd_ptr_q];
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_fault = out_valid && fault_mem_q[rd_ptr_q];
    assign occupancy = count_q;

    // Next-state computation for fetch tracking and FIFO pointers
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        araddr_d      = araddr_q;
        ar_hold_d     = ar_hold_q;
        ar_stale_d    = ar_stale_q;
        fault_stall_d = fault_stall_q;
        outstanding_d = outstanding_q;
        stale_cnt_d   = stale_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        // Address channel: keep the request stable until it is taken
        if (w_ar_fire) begin
            ar_hold_d  = 1'b0;
            ar_stale_d = 1'b0;
        end else if (imem_arvalid) begin
            ar_hold_d  = 1'b1;
            araddr_d   = imem_araddr;
            ar_stale_d = ar_stale_q || redirect_valid;
        end

        if (w_ar_fire && !w_ar_is_stale) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        case ({w_ar_fire, w_r_fire})
            2'b10:   outstanding_d = outstanding_q + c_OST_W'(1);
            2'b01:   outstanding_d = outstanding_q - c_OST_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (w_drop) begin
            stale_cnt_d = stale_cnt_d - c_OST_W'(1);
        end
        if (w_ar_fire && w_ar_is_stale) begin
            stale_cnt_d = stale_cnt_d + c_OST_W'(1);
        end

        if (w_push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + c_PTR_W'(1);
            if (imem_rresp != 2'b00) begin
                fault_stall_d = 1'b1;
            end
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Redirect overrides everything: every read still in flight is stale
        if (redirect_valid) begin
            fetch_pc_d    = redirect_pc;
            resp_pc_d     = redirect_pc;
            fault_stall_d = 1'b0;
            stale_cnt_d   = outstanding_d;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            araddr_q      <= RESET_PC;
            ar_hold_q     <= 1'b0;
            ar_stale_q    <= 1'b0;
            fault_stall_q <= 1'b0;
            outstanding_q <= '0;
            stale_cnt_q   <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            araddr_q      <= araddr_d;
            ar_hold_q     <= ar_hold_d;
            ar_stale_q    <= ar_stale_d;
            fault_stall_q <= fault_stall_d;
            outstanding_q <= outstanding_d;
            stale_cnt_q   <= stale_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            inst_mem_q[wr_ptr_q]  <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= resp_pc_q;
            fault_mem_q[wr_ptr_q] <= (imem_rresp != 2'b00);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25040109_ifu_prefetch.sv
// ============================================================================
// Module      : tb_ysyx_25040109_ifu_prefetch
// Description : Scoreboard bench for the prefetching fetch unit. A memory
//               slave answers reads in order with data = ~address; expected
//               AR addresses and FIFO outputs are queued per test and popped
//               by an independent monitor on every handshake.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ysyx_25040109_ifu_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_arvalid;
    logic        imem_arready;
    logic [31:0] imem_araddr;
    logic        imem_rvalid;
    logic        imem_rready;
    logic [31:0] imem_rdata;
    logic [1:0]  imem_rresp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_fault;
    logic [2:0]  occupancy;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t        exp_out[$];
    logic [31:0] exp_ar[$];
    logic [31:0] pend[$];

    int          total = 0;
    int          bad   = 0;
    bit          ar_en = 1'b0;
    bit          r_en  = 1'b0;
    bit          fault_on = 1'b0;
    logic [31:0] fault_addr = 32'h0;

    ysyx_25040109_ifu_prefetch #(
        .DEPTH          (4),
        .MAX_OUTSTANDING(2),
        .RESET_PC       (32'h8000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_arvalid  (imem_arvalid),
        .imem_arready  (imem_arready),
        .imem_araddr   (imem_araddr),
        .imem_rvalid   (imem_rvalid),
        .imem_rready   (imem_rready),
        .imem_rdata    (imem_rdata),
        .imem_rresp    (imem_rresp),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .out_fault     (out_fault),
        .occupancy     (occupancy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_out(input logic [31:0] pc, input logic fault);
        exp_t e;
        e.pc    = pc;
        e.inst  = ~pc;
        e.fault = fault;
        exp_out.push_back(e);
    endtask

    // Memory slave: in-order responses, one cycle after acceptance at the earliest
    initial begin
        imem_arready = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        imem_rresp   = 2'b00;
        forever begin
            @(negedge clk);
            #1;
            imem_arready = ar_en;
            if (r_en && pend.size() > 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = ~pend[0];
                imem_rresp  = (fault_on && pend[0] == fault_addr) ? 2'd2 : 2'd0;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
                imem_rresp  = 2'b00;
            end
            #2;
            if (imem_rvalid && imem_rready) void'(pend.pop_front());
            if (imem_arvalid && imem_arready) pend.push_back(imem_araddr);
        end
    end

    // Monitor: checks every accepted request and every FIFO pop against the queues
    initial begin
        exp_t        e;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                if (imem_arvalid && imem_arready) begin
                    if (exp_ar.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL ar_unexpected: got araddr %h want none", imem_araddr);
                    end else begin
                        a = exp_ar.pop_front();
                        chk("araddr", imem_araddr, a);
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_out.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL out_unexpected: got pc %h want none", out_pc);
                    end else begin
                        e = exp_out.pop_front();
                        chk("out_pc", out_pc, e.pc);
                        chk("out_inst", out_inst, e.inst);
                        chk("out_fault", {31'b0, out_fault}, {31'b0, e.fault});
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        out_ready = 1'b0; ar_en = 1'b0; r_en = 1'b0; fault_on = 1'b0;
        @(negedge clk);
        #2;
        chk("rst_arvalid", {31'b0, imem_arvalid}, 32'd0);
        chk("rst_rready", {31'b0, imem_rready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_fault", {31'b0, out_fault}, 32'd0);
        chk("rst_occupancy", {29'b0, occupancy}, 32'd0);
        pend.delete();
        exp_out.delete();
        exp_ar.delete();
    endtask

    task automatic end_test(input int n);
        repeat (n) @(negedge clk);
        #2;
        chk("exp_out_left", exp_out.size(), 32'd0);
        chk("exp_ar_left", exp_ar.size(), 32'd0);
        exp_out.delete();
        exp_ar.delete();
    endtask

    initial begin
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;

        // Test 1: streaming fetch, one instruction per cycle after fill
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_ar.push_back(32'h8000_0000 + 32'(4 * i));
            push_out(32'h8000_0000 + 32'(4 * i), 1'b0);
        end
        @(negedge clk); rst = 1'b1; out_ready = 1'b1;
        #2;
        chk("t1_first_arvalid", {31'b0, imem_arvalid}, 32'd1);
        chk("t1_first_araddr", imem_araddr, 32'h8000_0000);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin ar_en = 1'b1; r_en = 1'b1; end
            if (i == 9) ar_en = 1'b0;
            #2;
            if (i >= 3) chk("t1_steady_valid", {31'b0, out_valid}, 32'd1);
        end
        end_test(4);

        // Test 2: consumer stalled, fetch stops when FIFO credit runs out
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_ar.push_back(32'h8000_0000 + 32'(4 * i));
            push_out(32'h8000_0000 + 32'(4 * i), 1'b0);
        end
        @(negedge clk); rst = 1'b1; ar_en = 1'b1; r_en = 1'b1; out_ready = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        chk("t2_occupancy_full", {29'b0, occupancy}, 32'd4);
        chk("t2_arvalid_full", {31'b0, imem_arvalid}, 32'd0);
        chk("t2_out_valid_full", {31'b0, out_valid}, 32'd1);
        @(negedge clk); out_ready = 1'b1; ar_en = 1'b0;
        #2;
        chk("t2_arvalid_pop_cycle", {31'b0, imem_arvalid}, 32'd0);
        @(negedge clk);
        #2;
        chk("t2_arvalid_after_pop", {31'b0, imem_arvalid}, 32'd1);
        chk("t2_araddr_after_pop", imem_araddr, 32'h8000_0010);
        chk("t2_occupancy_after_pop", {29'b0, occupancy}, 32'd3);
        end_test(6);

        // Test 3: redirect with two reads in flight
        do_reset();
        exp_ar.push_back(32'h8000_0000);
        exp_ar.push_back(32'h8000_0004);
        exp_ar.push_back(32'h8000_1000);
        push_out(32'h8000_1000, 1'b0);
        @(negedge clk); rst = 1'b1; ar_en = 1'b1; r_en = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
        #2;
        chk("t3_arvalid_redirect", {31'b0, imem_arvalid}, 32'd0);
        @(negedge clk); redirect_valid = 1'b0; r_en = 1'b1;
        #2;
        chk("t3_occupancy_after", {29'b0, occupancy}, 32'd0);
        chk("t3_out_valid_after", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        #2;
        chk("t3_out_valid_dropped", {31'b0, out_valid}, 32'd0);
        chk("t3_arvalid_new", {31'b0, imem_arvalid}, 32'd1);
        chk("t3_araddr_new", imem_araddr, 32'h8000_1000);
        @(negedge clk); ar_en = 1'b0;
        @(negedge clk);
        #2;
        chk("t3_out_valid_new", {31'b0, out_valid}, 32'd1);
        chk("t3_out_pc_new", out_pc, 32'h8000_1000);
        end_test(4);

        // Test 4: request held across a redirect becomes stale
        do_reset();
        exp_ar.push_back(32'h8000_0000);
        exp_ar.push_back(32'h8000_2000);
        push_out(32'h8000_2000, 1'b0);
        @(negedge clk); rst = 1'b1; ar_en = 1'b0; r_en = 1'b1; out_ready = 1'b1;
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h8000_2000;
        #2;
        chk("t4_held_arvalid", {31'b0, imem_arvalid}, 32'd1);
        chk("t4_held_araddr", imem_araddr, 32'h8000_0000);
        @(negedge clk); redirect_valid = 1'b0; ar_en = 1'b1;
        #2;
        chk("t4_held_after_redirect", imem_araddr, 32'h8000_0000);
        @(negedge clk);
        #2;
        chk("t4_next_arvalid", {31'b0, imem_arvalid}, 32'd1);
        chk("t4_next_araddr", imem_araddr, 32'h8000_2000);
        chk("t4_stale_not_pushed", {31'b0, out_valid}, 32'd0);
        @(negedge clk); ar_en = 1'b0;
        @(negedge clk);
        #2;
        chk("t4_out_pc", out_pc, 32'h8000_2000);
        end_test(4);

        // Test 5: access fault on the third response stalls fetch until redirect
        do_reset();
        fault_on = 1'b1; fault_addr = 32'h8000_0008;
        for (int i = 0; i < 4; i++) begin
            exp_ar.push_back(32'h8000_0000 + 32'(4 * i));
            push_out(32'h8000_0000 + 32'(4 * i), (i == 2));
        end
        exp_ar.push_back(32'h8000_3000);
        push_out(32'h8000_3000, 1'b0);
        @(negedge clk); rst = 1'b1; ar_en = 1'b1; r_en = 1'b1; out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        chk("t5_fault_head", {31'b0, out_fault}, 32'd1);
        chk("t5_fault_pc", out_pc, 32'h8000_0008);
        chk("t5_stall_arvalid", {31'b0, imem_arvalid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #2;
            chk("t5_stall_hold", {31'b0, imem_arvalid}, 32'd0);
        end
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h8000_3000;
        @(negedge clk); redirect_valid = 1'b0;
        #2;
        chk("t5_resume_arvalid", {31'b0, imem_arvalid}, 32'd1);
        chk("t5_resume_araddr", imem_araddr, 32'h8000_3000);
        @(negedge clk); ar_en = 1'b0;
        end_test(4);

        // Test 6: reset mid-operation with two reads in flight
        do_reset();
        exp_ar.push_back(32'h8000_0000);
        exp_ar.push_back(32'h8000_0004);
        exp_ar.push_back(32'h8000_0000);
        push_out(32'h8000_0000, 1'b0);
        @(negedge clk); rst = 1'b1; ar_en = 1'b1; r_en = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); ar_en = 1'b0; rst = 1'b0;
        @(negedge clk);
        #2;
        chk("t6_arvalid", {31'b0, imem_arvalid}, 32'd0);
        chk("t6_rready", {31'b0, imem_rready}, 32'd0);
        chk("t6_out_valid", {31'b0, out_valid}, 32'd0);
        chk("t6_out_fault", {31'b0, out_fault}, 32'd0);
        chk("t6_occupancy", {29'b0, occupancy}, 32'd0);
        @(negedge clk); rst = 1'b1; r_en = 1'b1;
        #2;
        chk("t6_restart_arvalid", {31'b0, imem_arvalid}, 32'd1);
        chk("t6_restart_araddr", imem_araddr, 32'h8000_0000);
        @(negedge clk); ar_en = 1'b1;
        @(negedge clk); ar_en = 1'b0;
        #2;
        chk("t6_old_dropped", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        #2;
        chk("t6_new_valid", {31'b0, out_valid}, 32'd1);
        chk("t6_new_pc", out_pc, 32'h8000_0000);
        end_test(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
